speck32_decrypt: RTL
====================

Name: speck32_decrypt

Overview:
- Iterative SPECK-32/64 decryption engine: one inverse round per clock, 22 rounds, consuming the precomputed 22 round keys in reverse order (key 21 down to key 0).
- Pairs with the existing SPECK-32/64 encryption core and shares its round-key bus format.
- It sits downstream of the same key-schedule block and returns plaintext through a valid/acknowledge output handshake.

Parameters:
- ROUNDS, 22, number of rounds; allRoundKeys width is 16*ROUNDS.
- ALPHA, 7, rotation amount applied to the x word.
- BETA, 2, rotation amount applied to the y word.

Ports:
- clock  input  1  single clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  32  ciphertext block; x = din[31:16], y = din[15:0].
- allRoundKeys  input  352  round key i is at allRoundKeys[16*i+15:16*i], for i = 0..21.
- din_valid  input  1  request to decrypt din; sampled only in IDLE.
- dout_ack  input  1  consumer has taken dout; sampled only in DONE.
- busy  output  1  high from the accept edge until the result is written.
- dout_ready  output  1  high while dout holds a valid plaintext.
- dout  output  32  registered plaintext; x in [31:16], y in [15:0].

Behaviour:
- Reset (reset=1 at a clock edge):
  - state goes to IDLE, round counter to 0, working x/y to 0, dout to 0, busy to 0, dout_ready to 0.
  - Reset wins over every other input, including in the middle of an operation; any partial result is discarded.
- Inverse round, applied with key k to words (x, y), all arithmetic mod 2^16:
  - y' = ROR16(x XOR y, BETA)
  - x' = ROL16((x XOR k) - y', ALPHA)
- States: IDLE, DECRYPT, DONE.
- IDLE:
  - When din_valid=1: capture din into x/y, set round counter to ROUNDS-1 (21), busy=1, go to DECRYPT.
  - When din_valid=0: remain in IDLE.
- DECRYPT:
  - Each edge applies one inverse round using key[round] and decrements the counter.
  - On the edge where the counter is 0: apply the final round, write the result straight into dout, busy=0, dout_ready=1, go to DONE.
  - din_valid is ignored; no restart and no abort except by reset.
- Latency: the accept edge plus 22 round edges. dout_ready is first visible 22 cycles after the accept edge (23 edges counting the accept edge).
- DONE:
  - dout and dout_ready are held stable indefinitely until dout_ack=1.
  - On dout_ack: dout_ready=0, go to IDLE; dout keeps its last value.
  - din_valid in the same cycle as dout_ack is not accepted. The earliest new accept is the next edge in IDLE, so the minimum spacing is 24 cycles per block.
- The counter never wraps: it only decrements from 21 to 0, and the 0 case exits DECRYPT.
- Without the optional feature, allRoundKeys must be stable from the accept edge until dout_ready rises; behaviour is undefined if it changes.

Optional Feature:
- Macro: SPECK_DEC_KEY_LATCH_EN.
- Defined:
  - A 352-bit internal key register captures allRoundKeys on the accept edge; all rounds use this register.
  - allRoundKeys may change freely while busy=1 without affecting the result.
  - The key register is cleared by reset.
- Undefined: no key register; rounds index allRoundKeys directly, and the stability rule in Behaviour applies.

Test Plan:
- Known vector:
  - Master key 1918 1110 0908 0100; the bench model generates the 22 round keys (k0 = 16'h0100).
  - Drive din = 32'ha86842f2 with a 1-cycle din_valid pulse.
  - Expect dout = 32'h6574694c with dout_ready rising exactly 22 cycles after the accept edge, and busy high for exactly 22 cycles.
- Hold and acknowledge:
  - After dout_ready rises, delay dout_ack by 5 cycles.
  - Expect dout and dout_ready stable for all 5 cycles, then dout_ready=0 one edge after dout_ack, and the state back in IDLE.
- Busy ignore:
  - Accept 32'ha86842f2, then drive din_valid=1 with din = 32'h12345678 throughout DECRYPT.
  - Expect the result still 32'h6574694c and no second operation started before dout_ack.
- Reset mid-operation:
  - Assert reset for 1 cycle at round 10.
  - Expect busy=0, dout_ready=0, dout=0 on the next edge.
  - A fresh request then yields the correct result with full 22-cycle latency.
- Back-to-back versus model:
  - Run 200 random din/key pairs with dout_ack asserted in the same cycle dout_ready rises.
  - Expect every dout to match the bench model, and encrypt-core output fed into this block to return the original plaintext.
- Key latch (SPECK_DEC_KEY_LATCH_EN defined):
  - Accept the known vector, then replace allRoundKeys with random data at round 15.
  - Expect dout = 32'h6574694c.
  - With the macro undefined, the same stimulus is not required to match; the bench checks only the stable-key case.

Source files
------------

// File: rtl/speck32_decrypt.sv
// Iterative SPECK-32/64 decryption core: one inverse round per clock, round keys consumed 21 down to 0.
// Optional macro SPECK_DEC_KEY_LATCH_EN latches allRoundKeys on accept so the key bus may change mid-block.
module speck32_decrypt #(
  parameter int ROUNDS = 22,
  parameter int ALPHA  = 7,
  parameter int BETA   = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            din,
  input  logic [16*ROUNDS-1:0]   allRoundKeys,
  input  logic                   din_valid,
  input  logic                   dout_ack,
  output logic                   busy,
  output logic                   dout_ready,
  output logic [31:0]            dout
);

  localparam int CNT_W = $clog2(ROUNDS);

  typedef enum logic [1:0] {IDLE, DECRYPT, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   rnd_q;
  logic [15:0]        x_q, y_q;
  logic [15:0]        rk, x_nx, y_nx;
  logic [16*ROUNDS-1:0] key_src;

  function automatic logic [15:0] rol_alpha(input logic [15:0] v);
    logic [31:0] t;
    t = {v, v} << ALPHA;
    return t[31:16];
  endfunction

  function automatic logic [15:0] ror_beta(input logic [15:0] v);
    logic [31:0] t;
    t = {v, v} >> BETA;
    return t[15:0];
  endfunction

`ifdef SPECK_DEC_KEY_LATCH_EN
  logic [16*ROUNDS-1:0] key_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      key_q <= '0;
    end else if (state_q == IDLE && din_valid) begin
      key_q <= allRoundKeys;
    end
  end

  assign key_src = key_q;
`else
  assign key_src = allRoundKeys;
`endif

  // Round stage: inverse round on the working words with the key selected by the counter
  assign rk   = key_src[16*rnd_q +: 16];
  assign y_nx = ror_beta(x_q ^ y_q);
  assign x_nx = rol_alpha((x_q ^ rk) - y_nx);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (din_valid)     state_d = DECRYPT;
      DECRYPT: if (rnd_q == '0)   state_d = DONE;
      DONE:    if (dout_ack)      state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Final round writes straight into dout so the result appears on the 22nd round edge
  always_ff @(posedge clock) begin
    if (reset) begin
      rnd_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      dout       <= '0;
      busy       <= 1'b0;
      dout_ready <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (din_valid) begin
            x_q   <= din[31:16];
            y_q   <= din[15:0];
            rnd_q <= CNT_W'(ROUNDS - 1);
            busy  <= 1'b1;
          end
        end
        DECRYPT: begin
          x_q <= x_nx;
          y_q <= y_nx;
          if (rnd_q == '0) begin
            dout       <= {x_nx, y_nx};
            busy       <= 1'b0;
            dout_ready <= 1'b1;
          end else begin
            rnd_q <= rnd_q - 1'b1;
          end
        end
        DONE: begin
          if (dout_ack) dout_ready <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
